// File: rtl/micro_reg_file_mp_if.sv
// Bus bundle for the multi-port micro register file: read ports, write-back,
// scoreboard claim/flush and the registered status outputs.
interface micro_reg_file_mp_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_PORTS   = 2
);
   logic [RD_PORTS-1:0]            rd_en;
   logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
   logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic [RD_PORTS-1:0]            rd_valid;
   logic [RD_PORTS-1:0]            rd_hazard;
   logic                           wr_en;
   logic [ADDR_WIDTH-1:0]          wr_addr;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic                           claim_en;
   logic [ADDR_WIDTH-1:0]          claim_addr;
   logic                           flush;
   logic                           pending_any;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
      input  rd_data, rd_valid, rd_hazard, pending_any
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
      output rd_data, rd_valid, rd_hazard, pending_any
   );
endinterface

// File: rtl/micro_reg_file_mp.sv
// Multi-port micro register file: RD_PORTS registered read ports, one write
// port with optional same-cycle bypass, and a per-register pending scoreboard.
module micro_reg_file_mp #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int RD_PORTS   = 2,
   parameter bit ZERO_REG   = 1'b0,
   parameter bit BYPASS     = 1'b1
) (
   input logic                sys_clk,
   input logic                sys_reset,
   micro_reg_file_mp_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

   // An address is usable when it exists and is not the hardwired zero register.
   function automatic logic f_addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < LP_DEPTH) && !(ZERO_REG && (a == '0));
   endfunction

   logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
   logic [DEPTH-1:0]               r_pending;
   logic [RD_PORTS*DATA_WIDTH-1:0] r_rd_data;
   logic [RD_PORTS-1:0]            r_rd_valid;
   logic                           r_pending_any;

   logic                           w_wr_ok;
   logic                           w_claim_ok;
   logic [DEPTH-1:0]               w_pending_nxt;
   logic [RD_PORTS-1:0]            w_rd_hazard;
   logic [RD_PORTS-1:0]            w_rd_accept;
   logic [RD_PORTS*DATA_WIDTH-1:0] w_rd_value;

   assign w_wr_ok    = bus.wr_en    && f_addr_ok(bus.wr_addr);
   assign w_claim_ok = bus.claim_en && f_addr_ok(bus.claim_addr);

   // Claim is applied after the write-back clear so a new producer wins;
   // flush overrides both.
   always_comb begin
      w_pending_nxt = r_pending;
      for (int j = 0; j < DEPTH; j++) begin
         if (w_wr_ok && (bus.wr_addr == ADDR_WIDTH'(j))) begin
            w_pending_nxt[j] = 1'b0;
         end
         if (w_claim_ok && (bus.claim_addr == ADDR_WIDTH'(j))) begin
            w_pending_nxt[j] = 1'b1;
         end
      end
      if (bus.flush) begin
         w_pending_nxt = '0;
      end
   end

   for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_ok;
      logic                  w_byp;
      logic                  w_pend;
      logic [DATA_WIDTH-1:0] w_mem_val;

      assign w_addr = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_ok   = f_addr_ok(w_addr);
      assign w_byp  = BYPASS && w_wr_ok && (bus.wr_addr == w_addr);

      always_comb begin
         w_pend    = 1'b0;
         w_mem_val = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (w_addr == ADDR_WIDTH'(j)) begin
               w_pend    = r_pending[j];
               w_mem_val = r_mem[j];
            end
         end
      end

      assign w_rd_hazard[gi] = bus.rd_en[gi] && w_ok && w_pend && !w_byp;
      assign w_rd_accept[gi] = bus.rd_en[gi] && !w_rd_hazard[gi];
      assign w_rd_value[gi*DATA_WIDTH +: DATA_WIDTH] =
         !w_ok ? '0 : (w_byp ? bus.wr_data : w_mem_val);
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         for (int j = 0; j < DEPTH; j++) begin
            r_mem[j] <= '0;
         end
         r_pending     <= '0;
         r_rd_data     <= '0;
         r_rd_valid    <= '0;
         r_pending_any <= 1'b0;
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            if (w_wr_ok && (bus.wr_addr == ADDR_WIDTH'(j))) begin
               r_mem[j] <= bus.wr_data;
            end
         end
         for (int i = 0; i < RD_PORTS; i++) begin
            if (w_rd_accept[i]) begin
               r_rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_rd_value[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         r_rd_valid    <= w_rd_accept;
         r_pending     <= w_pending_nxt;
         r_pending_any <= |w_pending_nxt;
      end
   end

   assign bus.rd_data     = r_rd_data;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_hazard   = w_rd_hazard;
   assign bus.pending_any = r_pending_any;

endmodule

// File: doc/micro_reg_file_mp.md
Name: micro_reg_file_mp

Overview:
Parametrised multi-port successor to the single-port micro register file. It provides RD_PORTS independent registered read ports and one synchronous write port. Same-cycle write-to-read bypass is included. A per-register pending scoreboard lets the micro-sequencer detect read-after-write hazards on micro-registers whose producer has issued but not yet written back. The block sits between the micro-decode pipeline register and the ALU/memory stage.

Parameters:
DEPTH, 16, number of micro-registers
DATA_WIDTH, 8, register width in bits
ADDR_WIDTH, $clog2(DEPTH), register address width
RD_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 0, 1 = register 0 hardwired to zero
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
sys_clk  in  1  clock, all state on rising edge
sys_reset  in  1  asynchronous, active-high reset
rd_en  in  RD_PORTS  per-port read request
rd_addr  in  RD_PORTS*ADDR_WIDTH  packed read addresses; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  RD_PORTS*DATA_WIDTH  packed registered read data
rd_valid  out  RD_PORTS  1-cycle pulse; rd_data slice is valid
rd_hazard  out  RD_PORTS  combinational; request on port i blocked by pending register
wr_en  in  1  write-back strobe
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
claim_en  in  1  mark claim_addr pending (producer issued)
claim_addr  in  ADDR_WIDTH  register to mark pending
flush  in  1  clear all pending bits
pending_any  out  1  registered OR of all pending bits

Behaviour:
- Reset (async assert, sync-safe deassert): all registers 0; pending 0; rd_data 0; rd_valid 0; pending_any 0. Reset mid-operation discards in-flight reads, and the next cycle shows rd_valid 0.
- Write: on an edge with wr_en=1 and wr_addr<DEPTH, mem[wr_addr] <= wr_data. Writes with wr_addr>=DEPTH are ignored. When ZERO_REG=1, writes to address 0 are ignored.
- Read latency is 1 cycle. When port i is accepted at edge N, rd_data[i] and rd_valid[i]=1 are visible after edge N. rd_valid drops after 1 cycle unless the port is re-accepted.
- Read acceptance: port i is accepted when rd_en[i]=1 and rd_hazard[i]=0.
- Non-accepted cycle: rd_data[i] holds its previous value and rd_valid[i]=0.
- Read value:
  - Address >=DEPTH, or address 0 with ZERO_REG=1, returns 0.
  - With BYPASS=1, wr_en=1 and wr_addr==rd_addr[i] (valid, writable), the read returns wr_data.
  - Otherwise the read returns the stored value before the edge.
- Multiple ports may read the same address in the same cycle, and all receive identical data.
- Scoreboard:
  - pending[a] is set at an edge when claim_en=1 and claim_addr==a.
  - pending[a] is cleared at an edge when wr_en=1 and wr_addr==a.
  - Same-edge claim and write to the same address: the set wins, because a new producer supersedes the old one.
  - Claims to addresses >=DEPTH are ignored. Claims to address 0 are ignored when ZERO_REG=1.
- rd_hazard[i] = rd_en[i] & pending[rd_addr[i]] & ~(BYPASS & wr_en & wr_addr==rd_addr[i]).
  - A write landing in the same cycle resolves the hazard only when BYPASS=1.
  - rd_hazard[i] is 0 for out-of-range addresses and for the zero register.
- flush=1 clears every pending bit at the edge and overrides a same-cycle claim. Writes and reads in the flush cycle proceed normally.
- pending_any is the registered OR of the next-state pending vector, so it is accurate one cycle after the causing edge.
- The block has no internal state machine beyond the pending vector and output registers. All outputs other than rd_hazard are registered.

Test Plan:
1. Reset, then write 0xA5 to r3. Next cycle read r3 on port 0 → rd_data[0]=0xA5 with rd_valid[0]=1 one cycle later; before the write, the same read returns 0x00.
2. BYPASS=1: same cycle wr r5=0x3C with port 0 and port 1 both reading r5 → both return 0x3C. With BYPASS=0, the same stimulus returns the old value 0x00 on both ports.
3. claim r7; next cycle read r7 → rd_hazard[0]=1, no rd_valid, rd_data held. wr r7=0x11 on the following cycle → the hazard clears in that cycle (BYPASS=1) and the read returns 0x11.
4. Same-edge claim r2 and wr r2=0x44 → pending[2] stays 1 (next read of r2 shows rd_hazard=1). flush plus claim r2 in the same cycle → pending_any=0 after the edge.
5. ZERO_REG=1: wr r0=0xFF, then read r0 → 0x00. claim r0 → pending_any stays 0 and rd_hazard=0.
6. Assert sys_reset asynchronously between edges while rd_valid=1 and r4=0x99 → rd_valid, rd_data and pending_any go to 0 immediately. After release, reading r4 returns 0x00.
